// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, default RAM geometry
// and the grant-id encoding.
package ram_arb_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational arbiter. ptr=0 favours A on a tie, ptr=1 favours B;
// fixed_prio makes A win whenever it requests.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[GNT_A] && (!req[GNT_B] || fixed_prio || !ptr)) begin
      gnt[GNT_A] = 1'b1;
    end else if (req[GNT_B]) begin
      gnt[GNT_B] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM between requesters A and B.
// Each command takes IDLE -> ACCESS -> RESP; all RAM-side and client-side outputs are registered.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_A,
  input  logic          WE_A,
  input  logic [AW-1:0] ADDR_A,
  input  logic [DW-1:0] WDATA_A,
  output logic          ACK_A,
  input  logic          REQ_B,
  input  logic          WE_B,
  input  logic [AW-1:0] ADDR_B,
  input  logic [DW-1:0] WDATA_B,
  output logic          ACK_B,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);

  state_t        state, state_n;
  gnt_id_t       gnt_id, gnt_id_n;
  logic          ptr_q, ptr_n;
  logic [1:0]    gnt;
  logic          ram_we_n, ack_a_n, ack_b_n, busy_n;
  logic [AW-1:0] ram_a_n;
  logic [DW-1:0] ram_di_n, rdata_n;

  rr_arbiter2 u_arb (
    .req        ({REQ_B, REQ_A}),
    .fixed_prio (FIXED_PRIO),
    .ptr        (ptr_q),
    .gnt        (gnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      gnt_id <= GNT_A;
      ptr_q  <= 1'b0;
      RAM_WE <= 1'b0;
      RAM_A  <= '0;
      RAM_DI <= '0;
      ACK_A  <= 1'b0;
      ACK_B  <= 1'b0;
      RDATA  <= '0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_n;
      gnt_id <= gnt_id_n;
      ptr_q  <= ptr_n;
      RAM_WE <= ram_we_n;
      RAM_A  <= ram_a_n;
      RAM_DI <= ram_di_n;
      ACK_A  <= ack_a_n;
      ACK_B  <= ack_b_n;
      RDATA  <= rdata_n;
      BUSY   <= busy_n;
    end
  end

  // Next state and next register values; the pointer moves only on a grant.
  always_comb begin
    state_n  = state;
    gnt_id_n = gnt_id;
    ptr_n    = ptr_q;
    ram_we_n = RAM_WE;
    ram_a_n  = RAM_A;
    ram_di_n = RAM_DI;
    rdata_n  = RDATA;
    ack_a_n  = 1'b0;
    ack_b_n  = 1'b0;
    busy_n   = BUSY;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (gnt[GNT_B]) begin
          state_n  = ACCESS;
          busy_n   = 1'b1;
          gnt_id_n = GNT_B;
          ptr_n    = 1'b0;
          ram_we_n = WE_B;
          ram_a_n  = ADDR_B;
          ram_di_n = WDATA_B;
        end else if (gnt[GNT_A]) begin
          state_n  = ACCESS;
          busy_n   = 1'b1;
          gnt_id_n = GNT_A;
          ptr_n    = 1'b1;
          ram_we_n = WE_A;
          ram_a_n  = ADDR_A;
          ram_di_n = WDATA_A;
        end
      end
      ACCESS: begin
        state_n  = RESP;
        busy_n   = 1'b1;
        ram_we_n = 1'b0;
        rdata_n  = RAM_DO;
        ack_a_n  = (gnt_id == GNT_A);
        ack_b_n  = (gnt_id == GNT_B);
      end
      RESP: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n  = IDLE;
        busy_n   = 1'b0;
        ram_we_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [3:0] data;
    int         dly;
  } cmd_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_A = 1'b0, WE_A = 1'b0, REQ_B = 1'b0, WE_B = 1'b0;
  logic [3:0] ADDR_A = 4'h0, WDATA_A = 4'h0, ADDR_B = 4'h0, WDATA_B = 4'h0;
  logic       ACK_A, ACK_B, BUSY, RAM_WE;
  logic [3:0] RDATA, RAM_A, RAM_DI, RAM_DO;

  logic       f_req_a = 1'b0, f_req_b = 1'b0;
  logic       f_ack_a, f_ack_b, f_busy, f_ram_we;
  logic [3:0] f_rdata, f_ram_a, f_ram_di;
  logic [3:0] f_ram_do = 4'h0;

  bit [3:0] mem  [16];
  bit [3:0] mmem [16];

  int tests = 0, fails = 0, cyc = 0;
  cmd_t qa[$], qb[$];
  bit   abort_a = 0, abort_b = 0;
  int   dly_a = 0, dly_b = 0, reqcyc_a = 0;
  int   ack_cyc_a = 0, ack_cyc_b = 0, we_cnt = 0;
  logic [3:0] we_addr_last = 4'h0;
  bit         log_port[$];
  logic [3:0] log_rd[$];

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.AW(4), .DW(4), .FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B), .ACK_B(ACK_B),
    .RDATA(RDATA), .BUSY(BUSY), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  ram_port_arbiter #(.AW(4), .DW(4), .FIXED_PRIO(1'b1)) dut_fix (
    .CLK(CLK), .RST(RST),
    .REQ_A(f_req_a), .WE_A(1'b0), .ADDR_A(4'h6), .WDATA_A(4'h0), .ACK_A(f_ack_a),
    .REQ_B(f_req_b), .WE_B(1'b0), .ADDR_B(4'h9), .WDATA_B(4'h0), .ACK_B(f_ack_b),
    .RDATA(f_rdata), .BUSY(f_busy), .RAM_WE(f_ram_we), .RAM_A(f_ram_a), .RAM_DI(f_ram_di),
    .RAM_DO(f_ram_do)
  );

  // RAM behind the arbiter: combinational read, write committed at the end of ACCESS
  // unless a reset lands on that edge.
  assign RAM_DO = mem[RAM_A];
  always @(posedge CLK) if (RAM_WE && !RST) mem[RAM_A] <= RAM_DI;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input logic we, input logic [3:0] addr, input logic [3:0] data, input int dly);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data; c.dly = dly;
    qa.push_back(c);
  endtask

  task automatic push_b(input logic we, input logic [3:0] addr, input logic [3:0] data, input int dly);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data; c.dly = dly;
    qb.push_back(c);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (!(qa.size() == 0 && qb.size() == 0 && !REQ_A && !REQ_B && !BUSY) && n < budget);
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles", tag, n);
    end
  endtask

  // Client A: holds a command until its ACK, then drops REQ or presents the next one.
  always @(negedge CLK) begin
    cmd_t c;
    if (abort_a) begin
      qa.delete(); REQ_A = 1'b0; dly_a = 0;
    end else begin
      if (ACK_A) REQ_A = 1'b0;
      if (!REQ_A && qa.size() > 0) begin
        if (dly_a >= qa[0].dly) begin
          c = qa.pop_front();
          WE_A = c.we; ADDR_A = c.addr; WDATA_A = c.data; REQ_A = 1'b1;
          dly_a = 0; reqcyc_a = cyc;
        end else dly_a++;
      end
    end
  end

  always @(negedge CLK) begin
    cmd_t c;
    if (abort_b) begin
      qb.delete(); REQ_B = 1'b0; dly_b = 0;
    end else begin
      if (ACK_B) REQ_B = 1'b0;
      if (!REQ_B && qb.size() > 0) begin
        if (dly_b >= qb[0].dly) begin
          c = qb.pop_front();
          WE_B = c.we; ADDR_B = c.addr; WDATA_B = c.data; REQ_B = 1'b1;
          dly_b = 0;
        end else dly_b++;
      end
    end
  end

  // Transaction-level model: a grant starts a 3-cycle command whose effect on the
  // memory image and read data is applied when it completes.
  int         m_phase = 0;
  bit         m_last_b = 1'b1, m_pick_b = 1'b0, m_we = 1'b0;
  logic [3:0] m_addr = 4'h0;
  logic       e_we = 1'b0, e_acka = 1'b0, e_ackb = 1'b0, e_busy = 1'b0, e_rd_known = 1'b1;
  logic [3:0] e_a = 4'h0, e_di = 4'h0, e_rdata = 4'h0;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_phase = 0; m_last_b = 1'b1;
      e_we = 0; e_a = 0; e_di = 0; e_acka = 0; e_ackb = 0; e_rdata = 0; e_busy = 0; e_rd_known = 1;
    end else if (m_phase == 0) begin
      e_acka = 0; e_ackb = 0; e_busy = 0;
      if (REQ_A || REQ_B) begin
        m_pick_b = (REQ_A && REQ_B) ? !m_last_b : REQ_B;
        m_last_b = m_pick_b;
        m_we   = m_pick_b ? WE_B : WE_A;
        m_addr = m_pick_b ? ADDR_B : ADDR_A;
        e_di   = m_pick_b ? WDATA_B : WDATA_A;
        e_a = m_addr; e_we = m_we; e_busy = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      e_we = 0;
      if (m_we) begin
        mmem[m_addr] = e_di; e_rd_known = 0;
      end else begin
        e_rdata = mmem[m_addr]; e_rd_known = 1;
      end
      e_acka = !m_pick_b; e_ackb = m_pick_b; m_phase = 2;
    end else begin
      e_acka = 0; e_ackb = 0; e_busy = 0; m_phase = 0;
    end
  end

  always @(negedge CLK) begin
    chk("ack_a", 32'(ACK_A), 32'(e_acka));
    chk("ack_b", 32'(ACK_B), 32'(e_ackb));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("ram_we", 32'(RAM_WE), 32'(e_we));
    chk("ram_a", 32'(RAM_A), 32'(e_a));
    chk("ram_di", 32'(RAM_DI), 32'(e_di));
    if (e_rd_known) chk("rdata", 32'(RDATA), 32'(e_rdata));
    chk("ack_excl", 32'(ACK_A & ACK_B), 32'd0);
    chk("f_ack_excl", 32'(f_ack_a & f_ack_b), 32'd0);
    chk("f_ram_we", 32'(f_ram_we), 32'd0);
    chk("f_rdata", 32'(f_rdata | f_ram_di), 32'd0);
    if (f_busy) chk("f_ram_a", 32'(f_ram_a == 4'h6 || f_ram_a == 4'h9), 32'd1);
    if (RAM_WE) begin we_cnt++; we_addr_last = RAM_A; end
    if (ACK_A || ACK_B) begin log_port.push_back(ACK_B); log_rd.push_back(RDATA); end
    if (ACK_A) ack_cyc_a = cyc;
    if (ACK_B) ack_cyc_b = cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, fa, fb;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ram_we", 32'(RAM_WE), 0);
    chk("rst_ram_a", 32'(RAM_A), 0);
    chk("rst_ram_di", 32'(RAM_DI), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    chk("rst_acks", 32'({ACK_A, ACK_B}), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Single write then read on port A
    we_cnt = 0;
    push_a(1'b1, 4'h3, 4'hA, 0);
    wait_idle(50, "t1w");
    chk("t1_we_pulses", 32'(we_cnt), 1);
    chk("t1_we_addr", 32'(we_addr_last), 3);
    log_port.delete(); log_rd.delete();
    push_a(1'b0, 4'h3, 4'h0, 0);
    wait_idle(50, "t1r");
    chk("t1_rdata", 32'(log_rd[0]), 32'hA);
    chk("t1_latency", 32'(ack_cyc_a - reqcyc_a), 2);

    // Contention: both held for 4 commands each, A favoured after a B grant
    push_b(1'b0, 4'h1, 4'h0, 0);
    wait_idle(50, "t2pre");
    log_port.delete(); log_rd.delete();
    for (int i = 0; i < 4; i++) begin
      push_a(1'b0, 4'(i), 4'h0, 0);
      push_b(1'b0, 4'(i + 8), 4'h0, 0);
    end
    wait_idle(100, "t2");
    chk("t2_count", 32'(log_port.size()), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", 32'(log_port[i]), 32'(i % 2));

    // Fill and readback through port B
    log_port.delete(); log_rd.delete();
    for (int i = 0; i < 16; i++) push_b(1'b1, 4'(i), 4'(i), 0);
    for (int i = 0; i < 16; i++) push_b(1'b0, 4'(i), 4'h0, 0);
    wait_idle(300, "t3");
    chk("t3_count", 32'(log_rd.size()), 32);
    for (int i = 0; i < 16; i++) chk("t3_readback", 32'(log_rd[16 + i]), 32'(i));

    // Reset in the ACCESS cycle of a write of 5 to addr 7
    push_b(1'b1, 4'h7, 4'h5, 0);
    n = 0;
    do begin @(negedge CLK); n++; end while (!BUSY && n < 20);
    chk("t4_we_in_access", 32'(RAM_WE), 1);
    RST = 1'b1; abort_b = 1'b1;
    @(negedge CLK);
    chk("t4_we_after_rst", 32'(RAM_WE), 0);
    chk("t4_no_ack", 32'({ACK_A, ACK_B}), 0);
    chk("t4_busy", 32'(BUSY), 0);
    chk("t4_mem7", 32'(mem[7]), 7);
    RST = 1'b0;
    @(posedge CLK); #1;
    abort_b = 1'b0;
    log_port.delete(); log_rd.delete();
    push_a(1'b0, 4'h7, 4'h0, 0);
    push_b(1'b0, 4'h3, 4'h0, 0);
    wait_idle(50, "t4");
    chk("t4_first_a", 32'(log_port[0]), 0);
    chk("t4_rd7", 32'(log_rd[0]), 7);
    chk("t4_second_b", 32'(log_port[1]), 1);
    chk("t4_rd3", 32'(log_rd[1]), 3);

    // Late arrival: B rises during A's ACCESS
    log_port.delete(); log_rd.delete();
    push_a(1'b0, 4'h5, 4'h0, 0);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!BUSY && n < 20);
    push_b(1'b0, 4'h9, 4'h0, 0);
    wait_idle(50, "t5");
    chk("t5_count", 32'(log_port.size()), 2);
    chk("t5_order", 32'({log_port[0], log_port[1]}), 32'b01);
    chk("t5_gap", 32'(ack_cyc_b - ack_cyc_a), 3);

    // Random traffic on both ports
    for (int i = 0; i < 200; i++) begin
      push_a(1'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
      push_b(1'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 4)));
    end
    wait_idle(5000, "rand");

    // Fixed-priority instance: A always wins while requesting
    @(negedge CLK);
    f_req_a = 1'b1; f_req_b = 1'b1; fa = 0; fb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); fa += int'(f_ack_a); fb += int'(f_ack_b);
    end
    f_req_a = 1'b0;
    chk("fix_a_acks", 32'(fa), 4);
    chk("fix_b_starved", 32'(fb), 0);
    fa = 0; fb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); fa += int'(f_ack_a); fb += int'(f_ack_b);
    end
    f_req_b = 1'b0;
    chk("fix_b_acks", 32'(fb), 2);
    chk("fix_a_none", 32'(fa), 0);
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
